hovalaag_mem_loader: RTL and testbench
======================================

Name: hovalaag_mem_loader

Overview:
- Downstream of the USB/EPP programming interface.
- Consumes its level-held program_set / input1_set / input2_set strobes and address/data buses, and writes them into an internal 256x32 program RAM and two 12-bit input RAMs.
- Provides registered read ports to the CPU core.
- Sequences a CPU hold/start handshake so the core never executes while memories are being loaded.

Parameters:
- INPUT_DEPTH, 256: entries per input RAM; legal range 1..8192.
- HOLD_CYCLES, 4: cycles cpu_hold stays asserted after the last active set cycle before the CPU is released.

Ports:
- clk  in  1  system clock; all inputs synchronous to it
- rst  in  1  asynchronous, active-high reset
- program_set  in  1  level; write program_data at program_addr while high
- program_addr  in  8  program RAM write address
- program_data  in  32  program RAM write data
- input1_set  in  1  level; write input_data to input RAM 1
- input2_set  in  1  level; write input_data to input RAM 2
- input_addr  in  13  input RAM write address
- input_data  in  12  input RAM write data
- prog_rd_addr  in  8  CPU program fetch address
- prog_rd_data  out  32  program word; 1-cycle registered latency
- in1_rd_addr  in  13  CPU input 1 read address
- in1_rd_data  out  12  input 1 word; 1-cycle latency
- in2_rd_addr  in  13  CPU input 2 read address
- in2_rd_data  out  12  input 2 word; 1-cycle latency
- cpu_hold  out  1  high = CPU core must stay halted/reset
- cpu_start  out  1  one-cycle pulse on release of the CPU
- write_count  out  16  number of qualified distinct writes since reset, saturating at 0xFFFF

Behaviour:
- Reset (async, active-high): FSM to ST_HOLD; cpu_hold=1, cpu_start=0, all rd_data=0, write_count=0, drain counter=0, previous-cycle capture registers=0. RAM contents are not cleared.
- Write arbitration: at most one write per cycle. Priority is program_set > input1_set > input2_set; a lower-priority set that is high in the same cycle is ignored.
- Writes occur on every clock edge while the winning set is high (idempotent repeat). This also supports the upstream fill mode, where the address increments every cycle with the set held high.
- Input address range: an input write with input_addr >= INPUT_DEPTH is dropped; there is no wrap and no aliasing.
- write_count increments by 1 on a performed write only when it is a "new" write:
  - set source differs from the previous cycle (including a rising set), or
  - address differs from the previous cycle's address.
  - Data-only changes do not count. The counter saturates.
- Reads:
  - rd_data is registered from rd_addr on each clk.
  - Read-during-write to the same address returns the old (pre-write) data.
  - An in*_rd_addr >= INPUT_DEPTH returns 0.
- FSM:
  - ST_HOLD: cpu_hold=1. Any set high -> ST_LOAD. Otherwise stay; the CPU is not released until the first load.
  - ST_LOAD: cpu_hold=1. While any set is high, stay. When no set is high -> ST_DRAIN with counter=HOLD_CYCLES, or straight to ST_RUN if HOLD_CYCLES=0.
  - ST_DRAIN: cpu_hold=1. Counter decrements each cycle; on reaching 0 -> ST_RUN. Any set high -> ST_LOAD (counter abandoned).
  - ST_RUN: cpu_hold=0. Any set high -> ST_LOAD; cpu_hold is registered high the following cycle, and that first write still occurs.
  - cpu_start=1 for exactly the first cycle in ST_RUN.
- Reset mid-load: the write in progress on the reset edge is not guaranteed; the FSM returns to ST_HOLD.

Test Plan:
- Program write: reset, program_set=1 for 3 cycles with addr 0x10, data 0xDEADBEEF, then 0 -> prog_rd_addr=0x10 reads 0xDEADBEEF after 1 cycle; write_count=1; cpu_hold falls exactly 4 cycles after set falls; cpu_start pulses once.
- Fill mode: input1_set=1 for 256 cycles, input_addr 0..255, data 0xABC -> every in1 address reads 0xABC; write_count=256; cpu_hold=1 throughout.
- Priority and range: program_set and input2_set high together -> only the program RAM changes. input1_set with input_addr=0x100 (depth 256) -> no write, write_count unchanged, in1_rd_addr=0x100 reads 0.
- Re-load during run: in ST_RUN, pulse input2_set 1 cycle at addr 5, data 0x123 -> cpu_hold high the next cycle, in2[5]=0x123, cpu_start re-pulses after HOLD_CYCLES.
- Read-during-write: prog[3]=0x11111111, then write 0x22222222 to addr 3 while prog_rd_addr=3 -> first read returns 0x11111111, next cycle 0x22222222.
- Async reset during ST_DRAIN -> outputs reset immediately without a clock edge; cpu_hold=1, cpu_start never pulses until a new load.

Source files
------------

// File: rtl/hovalaag_mem_loader.sv
// hovalaag_mem_loader: takes the level-held program/input set strobes from the
// programming interface and writes them into the program RAM and two input RAMs.
// It provides registered read ports to the CPU core and holds the core halted
// while memories are being loaded.
module hovalaag_mem_loader #(
    parameter int INPUT_DEPTH = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        program_set,
    input  logic [7:0]  program_addr,
    input  logic [31:0] program_data,
    input  logic        input1_set,
    input  logic        input2_set,
    input  logic [12:0] input_addr,
    input  logic [11:0] input_data,
    input  logic [7:0]  prog_rd_addr,
    output logic [31:0] prog_rd_data,
    input  logic [12:0] in1_rd_addr,
    output logic [11:0] in1_rd_data,
    input  logic [12:0] in2_rd_addr,
    output logic [11:0] in2_rd_data,
    output logic        cpu_hold,
    output logic        cpu_start,
    output logic [15:0] write_count
);

    localparam int          IAW         = (INPUT_DEPTH > 1) ? $clog2(INPUT_DEPTH) : 1;
    localparam logic [13:0] DEPTH_LIMIT = 14'(INPUT_DEPTH);
    // The LOAD cycle in which every set drops already counts as the first hold
    // cycle, so the drain counter only has to cover the remaining ones.
    localparam logic [15:0] DRAIN_START = (HOLD_CYCLES > 1) ? 16'(HOLD_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PROG,
        SRC_IN1,
        SRC_IN2
    } src_e;

    logic [31:0] prog_mem [256];
    logic [11:0] in1_mem  [INPUT_DEPTH];
    logic [11:0] in2_mem  [INPUT_DEPTH];

    state_e      state_q, state_d;
    logic [15:0] drain_q, drain_d;
    logic        hold_q, hold_d;
    logic        start_q, start_d;

    src_e        src_sel, prev_src_q;
    logic [12:0] wr_addr, prev_addr_q;
    logic [15:0] write_count_q, write_count_d;

    logic [31:0] prog_rd_q;
    logic [11:0] in1_rd_q, in2_rd_q;

    logic any_set;
    logic in_range;
    logic do_write;
    logic is_new;
    logic in1_rd_ok;
    logic in2_rd_ok;

    assign any_set   = program_set | input1_set | input2_set;
    assign in_range  = {1'b0, input_addr} < DEPTH_LIMIT;
    assign in1_rd_ok = {1'b0, in1_rd_addr} < DEPTH_LIMIT;
    assign in2_rd_ok = {1'b0, in2_rd_addr} < DEPTH_LIMIT;

    // Pick the single winning write source for this cycle (program > input1 > input2).
    always_comb begin
        src_sel = SRC_NONE;
        wr_addr = '0;
        if (program_set) begin
            src_sel = SRC_PROG;
            wr_addr = {5'd0, program_addr};
        end else if (input1_set) begin
            src_sel = SRC_IN1;
            wr_addr = input_addr;
        end else if (input2_set) begin
            src_sel = SRC_IN2;
            wr_addr = input_addr;
        end
    end

    assign do_write = (src_sel == SRC_PROG) ||
                      (((src_sel == SRC_IN1) || (src_sel == SRC_IN2)) && in_range);
    assign is_new   = (src_sel != prev_src_q) || (wr_addr != prev_addr_q);

    // RAM write ports; contents survive reset, out-of-range input writes are dropped.
    always_ff @(posedge clk) begin
        if (src_sel == SRC_PROG) begin
            prog_mem[program_addr] <= program_data;
        end
        if ((src_sel == SRC_IN1) && in_range) begin
            in1_mem[input_addr[IAW-1:0]] <= input_data;
        end
        if ((src_sel == SRC_IN2) && in_range) begin
            in2_mem[input_addr[IAW-1:0]] <= input_data;
        end
    end

    // Registered read ports; a same-address write in this cycle is seen next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_rd_q <= '0;
            in1_rd_q  <= '0;
            in2_rd_q  <= '0;
        end else begin
            prog_rd_q <= prog_mem[prog_rd_addr];
            in1_rd_q  <= in1_rd_ok ? in1_mem[in1_rd_addr[IAW-1:0]] : 12'd0;
            in2_rd_q  <= in2_rd_ok ? in2_mem[in2_rd_addr[IAW-1:0]] : 12'd0;
        end
    end

    // Count only writes that change source or address, saturating at all-ones.
    always_comb begin
        write_count_d = write_count_q;
        if (do_write && is_new && (write_count_q != 16'hFFFF)) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    // Remember last cycle's winning source/address and the running write count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_count_q <= '0;
            prev_src_q    <= SRC_NONE;
            prev_addr_q   <= '0;
        end else begin
            write_count_q <= write_count_d;
            prev_src_q    <= src_sel;
            prev_addr_q   <= wr_addr;
        end
    end

    // Hold/start sequencing: load, drain for HOLD_CYCLES, then release the CPU.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_HOLD: begin
                if (any_set) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!any_set) begin
                    if (HOLD_CYCLES <= 1) begin
                        state_d = ST_RUN;
                        drain_d = '0;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_START;
                    end
                end
            end
            ST_DRAIN: begin
                if (any_set) begin
                    state_d = ST_LOAD;
                    drain_d = '0;
                end else if (drain_q <= 16'd1) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - 16'd1;
                end
            end
            ST_RUN: begin
                if (any_set) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_HOLD;
                drain_d = '0;
            end
        endcase
        hold_d  = (state_d != ST_RUN);
        start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // FSM state, drain counter and registered hold/start outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLD;
            drain_q <= '0;
            hold_q  <= 1'b1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            hold_q  <= hold_d;
            start_q <= start_d;
        end
    end

    assign prog_rd_data = prog_rd_q;
    assign in1_rd_data  = in1_rd_q;
    assign in2_rd_data  = in2_rd_q;
    assign cpu_hold     = hold_q;
    assign cpu_start    = start_q;
    assign write_count  = write_count_q;

endmodule

// File: tb/tb_hovalaag_mem_loader.sv
// Testbench for hovalaag_mem_loader: directed scenarios plus a randomized run,
// all checked against a behavioural model of the memories, the write counter
// and the hold/release timing.
module tb_hovalaag_mem_loader;

    localparam int DEPTH = 256;
    localparam int HOLD  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        program_set = 1'b0;
    logic [7:0]  program_addr = '0;
    logic [31:0] program_data = '0;
    logic        input1_set = 1'b0;
    logic        input2_set = 1'b0;
    logic [12:0] input_addr = '0;
    logic [11:0] input_data = '0;
    logic [7:0]  prog_rd_addr = '0;
    logic [31:0] prog_rd_data;
    logic [12:0] in1_rd_addr = '0;
    logic [11:0] in1_rd_data;
    logic [12:0] in2_rd_addr = '0;
    logic [11:0] in2_rd_data;
    logic        cpu_hold;
    logic        cpu_start;
    logic [15:0] write_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] mProg [256];
    bit          kProg [256];
    logic [11:0] mIn1  [DEPTH];
    bit          kIn1  [DEPTH];
    logic [11:0] mIn2  [DEPTH];
    bit          kIn2  [DEPTH];
    int          mCount;
    int          mPrevSrc;
    int          mPrevAddr;
    bit          mEverSet;
    int          mQuiet;
    bit          mHold;
    bit          mStart;
    logic [31:0] eProgRd;
    bit          eProgKnown;
    logic [11:0] eIn1Rd;
    bit          eIn1Known;
    logic [11:0] eIn2Rd;
    bit          eIn2Known;

    hovalaag_mem_loader #(
        .INPUT_DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .program_set  (program_set),
        .program_addr (program_addr),
        .program_data (program_data),
        .input1_set   (input1_set),
        .input2_set   (input2_set),
        .input_addr   (input_addr),
        .input_data   (input_data),
        .prog_rd_addr (prog_rd_addr),
        .prog_rd_data (prog_rd_data),
        .in1_rd_addr  (in1_rd_addr),
        .in1_rd_data  (in1_rd_data),
        .in2_rd_addr  (in2_rd_addr),
        .in2_rd_data  (in2_rd_data),
        .cpu_hold     (cpu_hold),
        .cpu_start    (cpu_start),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    // Clear the model's register state (RAM contents persist across reset).
    task automatic modelReset();
        mCount     = 0;
        mPrevSrc   = 0;
        mPrevAddr  = 0;
        mEverSet   = 0;
        mQuiet     = 0;
        mHold      = 1;
        mStart     = 0;
        eProgRd    = '0;
        eProgKnown = 1;
        eIn1Rd     = '0;
        eIn1Known  = 1;
        eIn2Rd     = '0;
        eIn2Known  = 1;
    endtask

    // Advance the model by one clock edge using the current inputs, then the DUT.
    task automatic tick();
        int src;
        int addr;
        int idx;
        bit wr;
        bit newHold;
        eProgKnown = kProg[int'(prog_rd_addr)];
        eProgRd    = mProg[int'(prog_rd_addr)];
        if (int'(in1_rd_addr) >= DEPTH) begin
            eIn1Rd = '0;
            eIn1Known = 1;
        end else begin
            idx = int'(in1_rd_addr);
            eIn1Rd = mIn1[idx];
            eIn1Known = kIn1[idx];
        end
        if (int'(in2_rd_addr) >= DEPTH) begin
            eIn2Rd = '0;
            eIn2Known = 1;
        end else begin
            idx = int'(in2_rd_addr);
            eIn2Rd = mIn2[idx];
            eIn2Known = kIn2[idx];
        end
        src  = program_set ? 1 : input1_set ? 2 : input2_set ? 3 : 0;
        addr = (src == 1) ? int'(program_addr) : (src >= 2) ? int'(input_addr) : 0;
        wr   = (src == 1) || ((src >= 2) && (int'(input_addr) < DEPTH));
        if (wr && ((src != mPrevSrc) || (addr != mPrevAddr)) && (mCount < 65535)) begin
            mCount++;
        end
        if (wr) begin
            if (src == 1) begin
                mProg[addr] = program_data;
                kProg[addr] = 1;
            end else if (src == 2) begin
                mIn1[addr] = input_data;
                kIn1[addr] = 1;
            end else begin
                mIn2[addr] = input_data;
                kIn2[addr] = 1;
            end
        end
        mPrevSrc  = src;
        mPrevAddr = addr;
        if (src != 0) begin
            mEverSet = 1;
            mQuiet   = 0;
        end else if (mQuiet < 1000) begin
            mQuiet++;
        end
        newHold = !(mEverSet && (mQuiet >= HOLD));
        mStart  = mHold && !newHold;
        mHold   = newHold;
        @(posedge clk);
        #1;
    endtask

    // Clear all write strobes.
    task automatic idleInputs();
        program_set = 1'b0;
        input1_set  = 1'b0;
        input2_set  = 1'b0;
    endtask

    // Hold reset for two edges and release it between edges.
    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        #1;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Outputs must take their reset values as soon as reset is raised.
    task automatic test_reset();
        idleInputs();
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        compared++;
        if (cpu_hold !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_hold actual=%b required=1", cpu_hold);
        end
        compared++;
        if (cpu_start !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_start actual=%b required=0", cpu_start);
        end
        compared++;
        if (write_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count actual=%0d required=0", write_count);
        end
        compared++;
        if ({prog_rd_data, in1_rd_data, in2_rd_data} !== 56'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd actual=%h/%h/%h required=0", prog_rd_data, in1_rd_data, in2_rd_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Repeated program write counts once; CPU released HOLD cycles after set drops.
    task automatic test_program_write();
        int fallAt = 0;
        int startCount = 0;
        doReset();
        prog_rd_addr = 8'h10;
        program_addr = 8'h10;
        program_data = 32'hDEADBEEF;
        program_set  = 1'b1;
        repeat (3) begin
            tick();
            compared++;
            if (cpu_hold !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL pw_hold_during actual=%b required=1", cpu_hold);
            end
        end
        program_set = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if ((cpu_hold === 1'b0) && (fallAt == 0)) fallAt = k;
            if (cpu_start === 1'b1) startCount++;
            compared++;
            if (cpu_hold !== mHold) begin
                mismatched++;
                $display("[TB] FAIL pw_hold k=%0d actual=%b required=%b", k, cpu_hold, mHold);
            end
        end
        compared++;
        if (fallAt != HOLD) begin
            mismatched++;
            $display("[TB] FAIL pw_release_delay actual=%0d required=%0d", fallAt, HOLD);
        end
        compared++;
        if (startCount != 1) begin
            mismatched++;
            $display("[TB] FAIL pw_start_pulses actual=%0d required=1", startCount);
        end
        compared++;
        if (prog_rd_data !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL pw_read actual=%h required=deadbeef", prog_rd_data);
        end
        compared++;
        if (write_count !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL pw_count actual=%0d required=1", write_count);
        end
    endtask

    // Fill input RAM 1 with an incrementing address, then read every entry back.
    task automatic test_fill();
        int bad = 0;
        doReset();
        input1_set = 1'b1;
        input_data = 12'hABC;
        for (int i = 0; i < 256; i++) begin
            input_addr = 13'(i);
            tick();
            if (cpu_hold !== 1'b1) bad++;
        end
        input1_set = 1'b0;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL fill_hold low_cycles=%0d required=0", bad);
        end
        compared++;
        if (write_count !== 16'd256) begin
            mismatched++;
            $display("[TB] FAIL fill_count actual=%0d required=256", write_count);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            in1_rd_addr = 13'(i);
            tick();
            if (in1_rd_data !== 12'hABC) begin
                bad++;
                if (bad <= 4) $display("[TB] FAIL fill_read addr=%0d actual=%h required=abc", i, in1_rd_data);
            end
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL fill_read_total bad=%0d required=0", bad);
        end
    endtask

    // Program beats input2 in the same cycle; out-of-range input address is ignored.
    task automatic test_priority_range();
        int countBefore;
        input2_set = 1'b1;
        input_addr = 13'h20;
        input_data = 12'h5A5;
        tick();
        idleInputs();
        tick();
        program_set  = 1'b1;
        input2_set   = 1'b1;
        program_addr = 8'h20;
        program_data = 32'hCAFEF00D;
        input_data   = 12'h777;
        tick();
        idleInputs();
        prog_rd_addr = 8'h20;
        in2_rd_addr  = 13'h20;
        tick();
        compared++;
        if (prog_rd_data !== 32'hCAFEF00D) begin
            mismatched++;
            $display("[TB] FAIL prio_prog actual=%h required=cafef00d", prog_rd_data);
        end
        compared++;
        if (in2_rd_data !== 12'h5A5) begin
            mismatched++;
            $display("[TB] FAIL prio_in2 actual=%h required=5a5", in2_rd_data);
        end
        countBefore = mCount;
        in1_rd_addr = 13'h100;
        input1_set  = 1'b1;
        input_addr  = 13'h100;
        input_data  = 12'hFFF;
        tick();
        input1_set = 1'b0;
        tick();
        compared++;
        if (int'(write_count) != countBefore) begin
            mismatched++;
            $display("[TB] FAIL range_count actual=%0d required=%0d", write_count, countBefore);
        end
        compared++;
        if (in1_rd_data !== 12'd0) begin
            mismatched++;
            $display("[TB] FAIL range_read actual=%h required=0", in1_rd_data);
        end
    endtask

    // A one-cycle load while running re-holds the CPU and restarts it later.
    task automatic test_reload_run();
        int startAt = 0;
        idleInputs();
        for (int w = 0; (w < 20) && (cpu_hold !== 1'b0); w++) tick();
        compared++;
        if (cpu_hold !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reload_reach_run actual=%b required=0", cpu_hold);
        end
        input2_set  = 1'b1;
        input_addr  = 13'd5;
        input_data  = 12'h123;
        in2_rd_addr = 13'd5;
        tick();
        input2_set = 1'b0;
        compared++;
        if (cpu_hold !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reload_hold actual=%b required=1", cpu_hold);
        end
        for (int k = 2; k <= 12; k++) begin
            tick();
            if ((cpu_start === 1'b1) && (startAt == 0)) startAt = k;
            if (k == 2) begin
                compared++;
                if (in2_rd_data !== 12'h123) begin
                    mismatched++;
                    $display("[TB] FAIL reload_in2 actual=%h required=123", in2_rd_data);
                end
            end
        end
        compared++;
        if (startAt != HOLD + 1) begin
            mismatched++;
            $display("[TB] FAIL reload_start_at actual=%0d required=%0d", startAt, HOLD + 1);
        end
    endtask

    // Read and write of the same program address in one cycle returns old data.
    task automatic test_read_during_write();
        program_set  = 1'b1;
        program_addr = 8'd3;
        program_data = 32'h11111111;
        tick();
        program_set = 1'b0;
        tick();
        prog_rd_addr = 8'd3;
        program_set  = 1'b1;
        program_data = 32'h22222222;
        tick();
        program_set = 1'b0;
        compared++;
        if (prog_rd_data !== 32'h11111111) begin
            mismatched++;
            $display("[TB] FAIL rdw_old actual=%h required=11111111", prog_rd_data);
        end
        tick();
        compared++;
        if (prog_rd_data !== 32'h22222222) begin
            mismatched++;
            $display("[TB] FAIL rdw_new actual=%h required=22222222", prog_rd_data);
        end
    endtask

    // Asynchronous reset while draining clears outputs at once and keeps the CPU held.
    task automatic test_reset_drain();
        int badCycles = 0;
        doReset();
        in1_rd_addr = 13'd7;
        input1_set  = 1'b1;
        input_addr  = 13'd7;
        input_data  = 12'h9C3;
        repeat (2) tick();
        input1_set = 1'b0;
        repeat (2) tick();
        compared++;
        if ((cpu_hold !== 1'b1) || (in1_rd_data !== 12'h9C3)) begin
            mismatched++;
            $display("[TB] FAIL drain_pre hold=%b rd=%h required=1/9c3", cpu_hold, in1_rd_data);
        end
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        compared++;
        if ((cpu_hold !== 1'b1) || (cpu_start !== 1'b0) || (write_count !== 16'd0) || (in1_rd_data !== 12'd0)) begin
            mismatched++;
            $display("[TB] FAIL drain_async hold=%b start=%b cnt=%0d rd=%h required=1/0/0/0",
                     cpu_hold, cpu_start, write_count, in1_rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if ((cpu_hold !== 1'b1) || (cpu_start !== 1'b0)) badCycles++;
        end
        compared++;
        if (badCycles != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_no_release bad_cycles=%0d required=0", badCycles);
        end
    endtask

    // Random bursts of writes and idle gaps, every output checked against the model.
    task automatic test_random();
        doReset();
        for (int seg = 0; seg < 50; seg++) begin
            int burst = $urandom_range(1, 8);
            int gap   = $urandom_range(0, 7);
            for (int c = 0; c < burst + gap; c++) begin
                if (c < burst) begin
                    program_set = 1'($urandom_range(0, 3) == 0);
                    input1_set  = 1'($urandom_range(0, 1));
                    input2_set  = 1'($urandom_range(0, 1));
                end else begin
                    idleInputs();
                end
                program_addr = 8'($urandom_range(0, 7));
                program_data = $urandom;
                input_addr   = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(253, 258))
                                                           : 13'($urandom_range(0, 7));
                input_data   = 12'($urandom);
                prog_rd_addr = 8'($urandom_range(0, 7));
                in1_rd_addr  = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(253, 258))
                                                           : 13'($urandom_range(0, 7));
                in2_rd_addr  = 13'($urandom_range(0, 7));
                tick();
                compared++;
                if ((cpu_hold !== mHold) || (cpu_start !== mStart)) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_ctrl hold/start actual=%b/%b required=%b/%b",
                             cpu_hold, cpu_start, mHold, mStart);
                end
                compared++;
                if (int'(write_count) != mCount) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_count actual=%0d required=%0d", write_count, mCount);
                end
                if (eProgKnown) begin
                    compared++;
                    if (prog_rd_data !== eProgRd) begin
                        mismatched++;
                        $display("[TB] FAIL rnd_prog actual=%h required=%h", prog_rd_data, eProgRd);
                    end
                end
                if (eIn1Known) begin
                    compared++;
                    if (in1_rd_data !== eIn1Rd) begin
                        mismatched++;
                        $display("[TB] FAIL rnd_in1 actual=%h required=%h", in1_rd_data, eIn1Rd);
                    end
                end
                if (eIn2Known) begin
                    compared++;
                    if (in2_rd_data !== eIn2Rd) begin
                        mismatched++;
                        $display("[TB] FAIL rnd_in2 actual=%h required=%h", in2_rd_data, eIn2Rd);
                    end
                end
            end
        end
        idleInputs();
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        for (int i = 0; i < 256; i++) begin
            kProg[i] = 0;
            mProg[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            kIn1[i] = 0;
            kIn2[i] = 0;
            mIn1[i] = '0;
            mIn2[i] = '0;
        end
        modelReset();
        test_reset();
        test_program_write();
        test_fill();
        test_priority_range();
        test_reload_run();
        test_read_during_write();
        test_reset_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
